pmem_arbiter: RTL and testbench

Shares the single physical-memory port between the pipelined I-cache (read-only) and the pipelined D-cache (read and write-back).
- Sits between both caches' pmem interfaces and the cacheline adapter / main memory.
- Grants one whole-line transaction at a time.
- Gives the D-cache priority, with a starvation bound so I-cache fetches always make progress.

---
 rtl/pmem_arbiter.sv | 72 +++++++
 tb/tb_pmem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between I-cache and D-cache, D priority with starvation bound
module pmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t                state, state_n;
  logic [3:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  d_pend, grant_i, grant_d, serving;
  assign d_pend  = d_pmem_read | d_pmem_write;
  assign grant_i = (state == IDLE) & i_pmem_read & (~d_pend | (starve_cnt == LIM));
  assign grant_d = (state == IDLE) & d_pend & ~grant_i;
  assign serving = (state == SERVE_I) | (state == SERVE_D);
  assign mem_read     = serving & ~wr_q;
  assign mem_write    = serving & wr_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  // next state: registered grant from IDLE, hold until mem_resp, one DONE cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (grant_i ? SERVE_I : grant_d ? SERVE_D : IDLE) :
              state == DONE ? IDLE : (mem_resp ? DONE : state);
  end
  // state, starvation counter and winner's request latched on the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE)
        starve_cnt <= (grant_i | ~i_pmem_read) ? 4'd0 :
                      (grant_d & (starve_cnt < LIM)) ? starve_cnt + 4'd1 : starve_cnt;
      if (grant_i | grant_d) begin
        addr_q  <= grant_i ? i_pmem_address : d_pmem_address;
        wr_q    <= grant_d & d_pmem_write;
        wdata_q <= grant_d ? d_pmem_wdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: vector table plus scoreboard of expected memory transactions
module tb_pmem_arbiter;
  logic         clk = 0, rst = 1;
  logic         i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0, mem_resp = 0;
  logic [31:0]  i_pmem_address = 0, d_pmem_address = 0;
  logic [255:0] d_pmem_wdata = 0, mem_rdata = 0;
  logic         i_pmem_resp, d_pmem_resp, mem_read, mem_write;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, mem_wdata;
  logic [31:0]  mem_address;
  int passed = 0, total = 0;

  typedef struct {bit is_d; bit wr; logic [31:0] addr; logic [255:0] wdata;} txn_t;
  typedef struct {bit i_rd; logic [31:0] i_a; bit d_rd; bit d_wr; logic [31:0] d_a;
                  logic [255:0] wd; bit exp_d; bit exp_wr; int lat; bit scr;} vec_t;
  txn_t exp_q[$];
  vec_t vecs[6];

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_A5A5}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [31:0] a, input logic [255:0] wd);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = wd;
    exp_q.push_back(t);
  endtask

  task automatic idle_chk(input string n);
    chk({n, "_strobes"}, {mem_read, mem_write}, 2'b00);
    chk({n, "_resps"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
  endtask

  task automatic serve(input int lat, input int exp_wait, input bit scr);
    txn_t t;
    int w;
    w = 0;
    while (!(mem_read || mem_write) && w < 8) begin tick(); w++; end
    chk("grant_wait", 256'(w), 256'(exp_wait));
    if (w >= 8 || exp_q.size() == 0) begin
      chk("scoreboard_has_txn", 256'(exp_q.size() != 0), 256'(1));
      return;
    end
    t = exp_q.pop_front();
    for (int k = 0; k < lat; k++) begin
      if (k > 0) tick();
      if (scr && k == 0) begin
        d_pmem_address = ~d_pmem_address;
        d_pmem_wdata   = ~d_pmem_wdata;
      end
      mem_resp  = (k == lat - 1);
      mem_rdata = mem_resp ? line(t.addr) : '0;
      #1;
      chk("mem_address", mem_address, t.addr);
      chk("mem_write", mem_write, t.wr);
      chk("mem_read", mem_read, !t.wr);
      if (t.wr) chk("mem_wdata", mem_wdata, t.wdata);
      chk("i_resp", i_pmem_resp, mem_resp && !t.is_d);
      chk("d_resp", d_pmem_resp, mem_resp && t.is_d);
    end
    chk("rdata", t.is_d ? d_pmem_rdata : i_pmem_rdata, line(t.addr));
    tick();
    mem_resp = 0;
    mem_rdata = '0;
    #1;
    idle_chk("done");
  endtask

  initial begin
    vecs[0] = '{1, 32'h40,   0, 0, 32'h0,    '0,                 0, 0, 3, 0};
    vecs[1] = '{0, 32'h0,    0, 1, 32'h1000, {8{32'hDEAD_BEEF}}, 1, 1, 2, 1};
    vecs[2] = '{0, 32'h0,    1, 0, 32'h2000, '0,                 1, 0, 1, 0};
    vecs[3] = '{0, 32'h0,    1, 1, 32'h2400, {8{32'h1234_5678}}, 1, 1, 1, 0};
    vecs[4] = '{1, 32'h80,   1, 0, 32'h3000, '0,                 1, 0, 2, 0};
    vecs[5] = '{1, 32'hC0,   0, 0, 32'h0,    '0,                 0, 0, 1, 0};

    repeat (3) tick();
    idle_chk("reset");
    chk("reset_starve", 256'(dut.starve_cnt), 256'(0));
    rst = 0;
    tick();
    idle_chk("idle_after_reset");

    for (int v = 0; v < 6; v++) begin
      i_pmem_read = vecs[v].i_rd; i_pmem_address = vecs[v].i_a;
      d_pmem_read = vecs[v].d_rd; d_pmem_write = vecs[v].d_wr;
      d_pmem_address = vecs[v].d_a; d_pmem_wdata = vecs[v].wd;
      push(vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_d ? vecs[v].d_a : vecs[v].i_a, vecs[v].wd);
      serve(vecs[v].lat, 1, vecs[v].scr);
      i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
      tick();
      idle_chk("idle");
    end

    i_pmem_read = 1; i_pmem_address = 32'h100;
    d_pmem_read = 1; d_pmem_address = 32'h5000;
    push(1, 0, 32'h5000, '0);
    serve(1, 1, 0);
    chk("starve_after_d", 256'(dut.starve_cnt), 256'(1));
    d_pmem_read = 0;
    push(0, 0, 32'h100, '0);
    serve(2, 2, 0);
    chk("starve_after_i", 256'(dut.starve_cnt), 256'(0));
    i_pmem_read = 0;
    tick();

    i_pmem_read = 1; i_pmem_address = 32'h200;
    d_pmem_read = 1; d_pmem_address = 32'h6000;
    for (int n = 0; n < 4; n++) push(1, 0, 32'h6000, '0);
    push(0, 0, 32'h200, '0);
    push(1, 0, 32'h6000, '0);
    for (int n = 0; n < 4; n++) serve(1, n == 0 ? 1 : 2, 0);
    chk("starve_at_limit", 256'(dut.starve_cnt), 256'(4));
    serve(1, 2, 0);
    i_pmem_read = 0;
    serve(1, 2, 0);
    d_pmem_read = 0;
    tick();
    idle_chk("after_starve");

    d_pmem_write = 1; d_pmem_address = 32'h7000; d_pmem_wdata = {8{32'hCAFE_F00D}};
    tick();
    chk("abort_write_strobe", mem_write, 1'b1);
    rst = 1;
    tick();
    rst = 0; d_pmem_write = 0;
    #1;
    idle_chk("abort");
    chk("abort_starve", 256'(dut.starve_cnt), 256'(0));
    mem_resp = 1;
    #1;
    chk("abort_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    tick();
    chk("abort_no_resp2", {i_pmem_resp, d_pmem_resp}, 2'b00);
    mem_resp = 0;
    tick();

    d_pmem_read = 1; d_pmem_address = 32'h8000;
    push(1, 0, 32'h8000, '0);
    serve(2, 1, 0);
    d_pmem_read = 0;
    tick();
    idle_chk("final");
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
